// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the icache/dcache main-memory arbiter.
// Purely declarative: no logic, no latency, no flow control.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        GNT_IC = 1'b0,
        GNT_DC = 1'b1
    } grant_t;

    localparam int LINE_W_DEF    = 128;
    localparam int ADDR_W_DEF    = 32;
    localparam int LINE_OFF_BITS = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: combinational grant, last winner registered on advance_i.
// Zero latency; a tie always goes to the requester that did not win last time.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output grant_t     grant_o
);

    grant_t last_q, last_d;

    always_comb begin
        grant_o = GNT_IC;
        case (req_i)
            2'b10:   grant_o = GNT_DC;
            2'b11:   grant_o = (last_q == GNT_IC) ? GNT_DC : GNT_IC;
            default: grant_o = GNT_IC;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i) begin
            last_d = grant_o;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= GNT_DC;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the main-memory line port between icache refill and dcache refill/write-back.
// Request-to-ready is LATENCY+1 cycles; requesters hold req until their ready pulse.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LATENCY = 10,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int LINE_W  = LINE_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_ready,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_ready,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata
);

    localparam int                CNT_W     = $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT  = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << LINE_OFF_BITS) - 1);

    state_t            state_q, state_d;
    grant_t            gnt_q, gnt_d, pick;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              is_write_q, is_write_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              ic_ready_q, ic_ready_d;
    logic              dc_ready_q, dc_ready_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic              advance;

    rr_arb2 u_rr (
        .clk       (clk),
        .reset     (reset),
        .req_i     ({dc_req, ic_req}),
        .advance_i (advance),
        .grant_o   (pick)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        count_d    = count_q;
        is_write_d = is_write_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_ready_d = 1'b0;
        dc_ready_d = 1'b0;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        advance    = 1'b0;

        case (state_q)
            IDLE: begin
                if (ic_req || dc_req) begin
                    advance = 1'b1;
                    gnt_d   = pick;
                    if (pick == GNT_DC) begin
                        addr_d     = dc_addr & LINE_MASK;
                        wdata_d    = dc_wdata;
                        is_write_d = dc_we;
                    end else begin
                        addr_d     = ic_addr & LINE_MASK;
                        wdata_d    = '0;
                        is_write_d = 1'b0;
                    end
                    count_d   = CNT_INIT;
                    mem_req_d = 1'b1;
                    // With a one-cycle access the strobe lands in the very first busy cycle.
                    mem_we_d  = is_write_d && (LATENCY == 1);
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (count_q == '0) begin
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                    if (gnt_q == GNT_IC) begin
                        ic_ready_d = 1'b1;
                        ic_rdata_d = mem_rdata;
                    end else begin
                        dc_ready_d = 1'b1;
                        if (!is_write_q) begin
                            dc_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    count_d  = count_q - CNT_W'(1);
                    mem_we_d = is_write_q && (count_q == CNT_W'(1));
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= GNT_DC;
            count_q    <= '0;
            is_write_q <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_ready_q <= 1'b0;
            dc_ready_q <= 1'b0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            count_q    <= count_d;
            is_write_q <= is_write_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_ready_q <= ic_ready_d;
            dc_ready_q <= dc_ready_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
        end
    end

    assign ic_ready  = ic_ready_q;
    assign dc_ready  = dc_ready_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant order, port timing, write strobe, rdata hold, reset abort.
// Inputs change 1 time unit after the rising edge; outputs are checked at that point.
module tb_mem_arbiter;

    localparam int LAT = 10;

    logic         clk = 1'b0;
    logic         reset;
    logic         ic_req, dc_req, dc_we;
    logic [31:0]  ic_addr, dc_addr;
    logic [127:0] dc_wdata, mem_rdata;
    logic         ic_ready, dc_ready, mem_req, mem_we;
    logic [127:0] ic_rdata, dc_rdata, mem_wdata;
    logic [31:0]  mem_addr;

    int errors = 0;
    int checks = 0;

    localparam logic [127:0] RD_A = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] RD_B = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
    localparam logic [127:0] RD_C = 128'hC0C0_C0C0_0000_1111_2222_3333_C0C0_C0C0;
    localparam logic [127:0] RD_D = 128'hD00D_D00D_4444_5555_6666_7777_D00D_D00D;
    localparam logic [127:0] RD_2 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] RD_E = 128'hEEEE_0000_EEEE_0000_EEEE_0000_EEEE_0000;
    localparam logic [127:0] RD_F = 128'hF00F_1234_F00F_5678_F00F_9ABC_F00F_DEF0;
    localparam logic [127:0] WD   = 128'hAAAA_AAAA_AAAA_AAAA_5555_5555_5555_5555;
    localparam logic [127:0] JUNK = 128'hDEAD_BEEF_DEAD_BEEF_DEAD_BEEF_DEAD_BEEF;

    mem_arbiter #(.LATENCY(LAT), .ADDR_W(32), .LINE_W(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .ic_req    (ic_req),
        .ic_addr   (ic_addr),
        .ic_ready  (ic_ready),
        .ic_rdata  (ic_rdata),
        .dc_req    (dc_req),
        .dc_we     (dc_we),
        .dc_addr   (dc_addr),
        .dc_wdata  (dc_wdata),
        .dc_ready  (dc_ready),
        .dc_rdata  (dc_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mem_req"},   128'(mem_req),   128'(0));
        chk({tag, "_mem_we"},    128'(mem_we),    128'(0));
        chk({tag, "_mem_addr"},  128'(mem_addr),  128'(0));
        chk({tag, "_mem_wdata"}, mem_wdata,       128'(0));
        chk({tag, "_ic_ready"},  128'(ic_ready),  128'(0));
        chk({tag, "_dc_ready"},  128'(dc_ready),  128'(0));
        chk({tag, "_ic_rdata"},  ic_rdata,        128'(0));
        chk({tag, "_dc_rdata"},  dc_rdata,        128'(0));
    endtask

    // Called in the request cycle (cycle 0); returns in cycle LAT+2 with the requester's req dropped.
    task automatic txn(input string tag, input bit is_ic, input logic [31:0] exp_addr,
                       input bit we, input logic [127:0] exp_wd);
        for (int c = 1; c <= LAT; c++) begin
            step();
            chk({tag, "_mem_req"},  128'(mem_req),  128'(1));
            chk({tag, "_mem_addr"}, 128'(mem_addr), 128'(exp_addr));
            chk({tag, "_mem_we"},   128'(mem_we),   128'(we && (c == LAT)));
            chk({tag, "_ready_early"}, 128'(ic_ready | dc_ready), 128'(0));
            if (we) chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
        end
        step();
        chk({tag, "_ic_ready"}, 128'(ic_ready), 128'(is_ic));
        chk({tag, "_dc_ready"}, 128'(dc_ready), 128'(!is_ic));
        chk({tag, "_req_done"}, 128'(mem_req),  128'(0));
        chk({tag, "_we_done"},  128'(mem_we),   128'(0));
        if (is_ic) ic_req = 1'b0;
        else dc_req = 1'b0;
        step();
        chk({tag, "_ready_late"}, 128'(ic_ready | dc_ready), 128'(0));
        chk({tag, "_idle_req"},   128'(mem_req),             128'(0));
    endtask

    initial begin
        reset = 1'b1;
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
        repeat (2) step();
        chk_zero("rst_init");
        reset = 1'b0;
        step();

        // Tie right after reset: IC first, DC follows back-to-back, both read.
        ic_req = 1'b1; ic_addr = 32'h0000_0044;
        dc_req = 1'b1; dc_addr = 32'h0000_0088; dc_we = 1'b0;
        mem_rdata = RD_A;
        txn("tie_ic", 1'b1, 32'h40, 1'b0, '0);
        chk("tie_ic_rdata", ic_rdata, RD_A);
        chk("tie_dc_rdata_untouched", dc_rdata, 128'(0));
        mem_rdata = RD_B;
        txn("tie_dc", 1'b0, 32'h80, 1'b0, '0);
        chk("tie_dc_rdata", dc_rdata, RD_B);
        chk("tie_ic_rdata_hold", ic_rdata, RD_A);

        // Next tie goes to IC again since DC won last.
        ic_req = 1'b1; ic_addr = 32'h0000_01C4;
        dc_req = 1'b1; dc_addr = 32'h0000_008F;
        mem_rdata = RD_C;
        txn("tie2_ic", 1'b1, 32'h1C0, 1'b0, '0);
        chk("tie2_ic_rdata", ic_rdata, RD_C);
        mem_rdata = RD_D;
        txn("tie2_dc", 1'b0, 32'h80, 1'b0, '0);
        chk("tie2_dc_rdata", dc_rdata, RD_D);

        // Lone IC read.
        ic_req = 1'b1; ic_addr = 32'h0000_0044;
        mem_rdata = RD_2;
        txn("ic_rd", 1'b1, 32'h40, 1'b0, '0);
        chk("ic_rd_rdata", ic_rdata, RD_2);
        chk("ic_rd_dc_hold", dc_rdata, RD_D);

        // DC write-back leaves dc_rdata alone.
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0104; dc_wdata = WD;
        mem_rdata = JUNK;
        txn("dc_wr", 1'b0, 32'h100, 1'b1, WD);
        chk("dc_wr_rdata_hold", dc_rdata, RD_D);
        dc_we = 1'b0;

        // Address change mid-transaction is ignored.
        ic_req = 1'b1; ic_addr = 32'h0000_0044;
        mem_rdata = RD_E;
        for (int c = 1; c <= LAT; c++) begin
            step();
            chk("addr_frz_mem_addr", 128'(mem_addr), 128'(32'h40));
            chk("addr_frz_mem_req",  128'(mem_req),  128'(1));
            if (c == 4) ic_addr = 32'h0000_0200;
        end
        step();
        chk("addr_frz_ic_ready", 128'(ic_ready), 128'(1));
        chk("addr_frz_ic_rdata", ic_rdata, RD_E);
        ic_req = 1'b0;
        step();

        // Reset in cycle 5 of a DC write aborts it without strobe or ready.
        dc_req = 1'b1; dc_we = 1'b1; dc_addr = 32'h0000_0300; dc_wdata = WD;
        for (int c = 1; c <= 4; c++) begin
            step();
            chk("abort_pre_mem_we",  128'(mem_we),  128'(0));
            chk("abort_pre_mem_req", 128'(mem_req), 128'(1));
        end
        step();
        reset = 1'b1; dc_req = 1'b0; dc_we = 1'b0;
        #1;
        chk_zero("rst_mid");
        for (int c = 0; c < 3; c++) begin
            step();
            chk("abort_rst_mem_we",   128'(mem_we),   128'(0));
            chk("abort_rst_dc_ready", 128'(dc_ready), 128'(0));
        end
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            step();
            chk("abort_post_mem_we",   128'(mem_we),   128'(0));
            chk("abort_post_dc_ready", 128'(dc_ready), 128'(0));
            chk("abort_post_mem_req",  128'(mem_req),  128'(0));
        end

        ic_req = 1'b1; ic_addr = 32'h0000_050C;
        mem_rdata = RD_F;
        txn("post_rst", 1'b1, 32'h500, 1'b0, '0);
        chk("post_rst_ic_rdata", ic_rdata, RD_F);
        chk("post_rst_dc_rdata", dc_rdata, 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
